// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared constants and state encoding for the decoder scan sequencer.
package decoder_scan_sequencer_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      s_idle  = 2'd0,
      s_dwell = 2'd1,
      s_gap   = 2'd2
   } scan_state_t;

endpackage

// File: rtl/decoder_scan_sequencer_scan_next_channel.sv
// Masked priority search: lowest enabled channel at or above 'from'
// (strictly above when incl=0). No wrap-around; found=0 if none.
module scan_next_channel
   import decoder_scan_sequencer_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  from,
   input  logic              incl,
   output logic [SEL_W-1:0]  ch,
   output logic              found
);

   // Walk downward so the last hit written is the lowest qualifying index.
   always_comb begin
      ch    = '0;
      found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && ((SEL_W'(i) > from) || (incl && (SEL_W'(i) == from)))) begin
            ch    = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scans the 3-to-8 decoder channels in ascending order with a programmable
// dwell per channel and a one-cycle enable-low gap between channels.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   s_idle  | no scan; en low, d holds last channel
//   s_dwell | en high on channel d while the dwell counter runs down
//   s_gap   | one cycle en low before the next (or wrapped) channel
module decoder_scan_sequencer
   import decoder_scan_sequencer_pkg::*;
#(
   parameter int DWELL_W = 8,
   parameter int PASS_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [NUM_CH-1:0]  mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   d,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               ch_strobe,
   output logic [PASS_W-1:0]  pass_cnt
);

   scan_state_t        state, state_nx;
   logic [DWELL_W-1:0] cnt, cnt_nx, cnt_load;
   logic               wrap, wrap_nx;
   logic [SEL_W-1:0]   d_nx, srch_from, srch_ch;
   logic               en_nx, busy_nx, done_nx, strobe_nx, srch_incl, srch_found;
   logic [PASS_W-1:0]  pass_nx;

   // A dwell of 0 behaves as 1, so the counter loads max(dwell,1)-1.
   assign cnt_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

   scan_next_channel u_next (
      .mask  (mask),
      .from  (srch_from),
      .incl  (srch_incl),
      .ch    (srch_ch),
      .found (srch_found)
   );

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= s_idle;
         cnt       <= '0;
         wrap      <= 1'b0;
         d         <= '0;
         en        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ch_strobe <= 1'b0;
         pass_cnt  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         wrap      <= wrap_nx;
         d         <= d_nx;
         en        <= en_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         ch_strobe <= strobe_nx;
         pass_cnt  <= pass_nx;
      end
   end

   // Next-state and next-output decode; stop overrides everything last.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      wrap_nx   = wrap;
      d_nx      = d;
      en_nx     = 1'b0;
      done_nx   = 1'b0;
      strobe_nx = 1'b0;
      pass_nx   = pass_cnt;
      // Search from channel 0 when starting or wrapping, else strictly above d.
      if ((state == s_idle) || ((state == s_gap) && wrap)) begin
         srch_from = '0;
         srch_incl = 1'b1;
      end else begin
         srch_from = d;
         srch_incl = 1'b0;
      end

      case (state)
         s_idle: begin
            if (start) begin
               if (srch_found) begin
                  state_nx  = s_dwell;
                  d_nx      = srch_ch;
                  en_nx     = 1'b1;
                  strobe_nx = 1'b1;
                  pass_nx   = '0;
                  cnt_nx    = cnt_load;
                  wrap_nx   = 1'b0;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         s_dwell: begin
            en_nx = 1'b1;
            if (cnt != '0) begin
               cnt_nx = cnt - DWELL_W'(1);
            end else if (srch_found) begin
               state_nx = s_gap;
               en_nx    = 1'b0;
               wrap_nx  = 1'b0;
            end else begin
               en_nx   = 1'b0;
               pass_nx = pass_cnt + PASS_W'(1);
               if (cont && (mask != '0)) begin
                  state_nx = s_gap;
                  wrap_nx  = 1'b1;
               end else begin
                  state_nx = s_idle;
                  done_nx  = 1'b1;
               end
            end
         end
         s_gap: begin
            if (srch_found) begin
               state_nx  = s_dwell;
               d_nx      = srch_ch;
               en_nx     = 1'b1;
               strobe_nx = 1'b1;
               cnt_nx    = cnt_load;
            end else begin
               state_nx = s_idle;
               done_nx  = 1'b1;
            end
            wrap_nx = 1'b0;
         end
         default: state_nx = s_idle;
      endcase

      if (stop) begin
         state_nx  = s_idle;
         cnt_nx    = cnt;
         wrap_nx   = 1'b0;
         d_nx      = d;
         en_nx     = 1'b0;
         done_nx   = 1'b0;
         strobe_nx = 1'b0;
         pass_nx   = pass_cnt;
      end

      busy_nx = (state_nx != s_idle);
   end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer with a negedge event monitor.
module tb_decoder_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, cont;
   logic [7:0] mask, dwell;
   logic [2:0] d;
   logic       en, busy, done, ch_strobe;
   logic [7:0] pass_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   int seq[$];
   int en_len[$];
   int busy_cyc, gap_cyc, done_cnt, clash;

   decoder_scan_sequencer #(.DWELL_W(8), .PASS_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .cont      (cont),
      .mask      (mask),
      .dwell     (dwell),
      .d         (d),
      .en        (en),
      .busy      (busy),
      .done      (done),
      .ch_strobe (ch_strobe),
      .pass_cnt  (pass_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Log channel visits, enable lengths, busy/gap cycles and done pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ch_strobe) begin
            seq.push_back(int'(d));
            en_len.push_back(0);
         end
         if (en && en_len.size() > 0)
            en_len[en_len.size()-1] = en_len[en_len.size()-1] + 1;
         if (busy) busy_cyc++;
         if (busy && !en) gap_cyc++;
         if (done) done_cnt++;
         if (done && ch_strobe) clash++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      seq.delete();
      en_len.delete();
      busy_cyc = 0;
      gap_cyc  = 0;
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      int i;
      i = 0;
      @(negedge clk);
      while (!done && i < lim) begin
         @(negedge clk);
         i++;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; stop = 1'b0; cont = 1'b0;
      mask  = 8'h00; dwell = 8'd0;
      clash = 0;
      clear_log();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_d", d, 0);
      chk("rst_en", en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_cnt, 0);

      // Full single pass, dwell 3.
      mask = 8'hFF; dwell = 8'd3; cont = 1'b0;
      clear_log();
      pulse_start();
      wait_done("full_done", 100);
      chk("full_en_at_done", en, 0);
      chk("full_busy_at_done", busy, 0);
      chk("full_d_at_done", d, 7);
      chk("full_pass", pass_cnt, 1);
      @(negedge clk);
      chk("full_nstrobe", seq.size(), 8);
      for (int i = 0; i < 8 && i < seq.size(); i++) begin
         chk($sformatf("full_seq%0d", i), seq[i], i);
         chk($sformatf("full_len%0d", i), en_len[i], 3);
      end
      chk("full_busy_cyc", busy_cyc, 31);
      chk("full_gap_cyc", gap_cyc, 7);
      chk("full_done_cnt", done_cnt, 1);

      // Sparse mask with dwell 0.
      mask = 8'b1010_0100; dwell = 8'd0;
      clear_log();
      pulse_start();
      wait_done("sparse_done", 50);
      @(negedge clk);
      chk("sparse_nstrobe", seq.size(), 3);
      if (seq.size() == 3) begin
         chk("sparse_ch0", seq[0], 2);
         chk("sparse_ch1", seq[1], 5);
         chk("sparse_ch2", seq[2], 7);
         for (int i = 0; i < 3; i++) chk($sformatf("sparse_len%0d", i), en_len[i], 1);
      end
      chk("sparse_busy_cyc", busy_cyc, 5);
      chk("sparse_pass", pass_cnt, 1);

      // Continuous wrap across channels 0 and 7.
      mask = 8'b1000_0001; dwell = 8'd2; cont = 1'b1;
      clear_log();
      pulse_start();
      for (int i = 0; i < 200 && pass_cnt != 8'd2; i++) @(negedge clk);
      chk("cont_reach_pass2", pass_cnt, 2);
      cont = 1'b0;
      wait_done("cont_done", 100);
      chk("cont_pass_final", pass_cnt, 3);
      @(negedge clk);
      chk("cont_nstrobe", seq.size(), 6);
      for (int i = 0; i < 6 && i < seq.size(); i++) begin
         chk($sformatf("cont_seq%0d", i), seq[i], (i % 2 == 0) ? 0 : 7);
         chk($sformatf("cont_len%0d", i), en_len[i], 2);
      end
      chk("cont_done_cnt", done_cnt, 1);

      // Stop during channel 3 dwell.
      mask = 8'hFF; dwell = 8'd5;
      clear_log();
      pulse_start();
      for (int i = 0; i < 200 && !(en && d == 3'd3); i++) @(negedge clk);
      chk("stop_reach_ch3", (en && d == 3'd3), 1);
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      chk("stop_en", en, 0);
      chk("stop_busy", busy, 0);
      chk("stop_d", d, 3);
      chk("stop_done", done, 0);
      repeat (6) @(negedge clk);
      chk("stop_no_done", done_cnt, 0);
      chk("stop_still_idle", busy, 0);

      // start and stop together in idle.
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("startstop_busy", busy, 0);
      chk("startstop_en", en, 0);

      // start while busy is ignored.
      mask = 8'b0001_0010; dwell = 8'd2;
      clear_log();
      pulse_start();
      pulse_start();
      wait_done("rebusy_done", 50);
      @(negedge clk);
      chk("rebusy_nstrobe", seq.size(), 2);
      if (seq.size() == 2) begin
         chk("rebusy_ch0", seq[0], 1);
         chk("rebusy_ch1", seq[1], 4);
      end
      chk("rebusy_pass", pass_cnt, 1);
      chk("rebusy_done_cnt", done_cnt, 1);

      // start with empty mask.
      mask = 8'h00;
      clear_log();
      pulse_start();
      @(negedge clk);
      chk("empty_done", done, 1);
      chk("empty_en", en, 0);
      chk("empty_busy", busy, 0);
      @(negedge clk);
      chk("empty_done_once", done, 0);
      chk("empty_nstrobe", seq.size(), 0);

      // Mask cleared during channel 4 dwell.
      mask = 8'hFF; dwell = 8'd4;
      clear_log();
      pulse_start();
      for (int i = 0; i < 200 && !(en && d == 3'd4); i++) @(negedge clk);
      chk("mclr_reach_ch4", (en && d == 3'd4), 1);
      mask = 8'h00;
      wait_done("mclr_done", 20);
      chk("mclr_en_at_done", en, 0);
      @(negedge clk);
      chk("mclr_nstrobe", seq.size(), 5);
      if (seq.size() == 5) begin
         chk("mclr_last_ch", seq[4], 4);
         chk("mclr_last_len", en_len[4], 4);
      end

      // Asynchronous reset mid-scan, with a nonzero pass count.
      mask = 8'h03; dwell = 8'd1; cont = 1'b1;
      pulse_start();
      for (int i = 0; i < 200 && !(en && pass_cnt == 8'd1); i++) @(negedge clk);
      chk("arst_reach", (en && pass_cnt == 8'd1), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en", en, 0);
      chk("arst_d", d, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_pass", pass_cnt, 0);
      cont = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      chk("no_done_strobe_clash", clash, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
